// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// matrix_pkg : shared state encoding and width helpers for matrix_mult_param
// Revision   : 1.0
// ============================================================================
package matrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOADED = 3'd2,
    ST_CALC   = 3'd3,
    ST_OUT    = 3'd4
  } state_e;

  function automatic int calc_dim_w(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int calc_acc_w(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

  // Row/column counters only ever hold 0..MAX_DIM-1
  function automatic int calc_idx_w(input int max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_mac.sv
`default_nettype none
// ============================================================================
// mat_mac  : registered multiply-accumulate with clear and enable
// Revision : 1.0
// ============================================================================
module mat_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  // Operands are widened to the accumulator width before multiplying
  generate
    if (SIGNED) begin : g_signed
      assign prod = ACC_W'($signed(a)) * ACC_W'($signed(b));
    end else begin : g_unsigned
      assign prod = ACC_W'(a) * ACC_W'(b);
    end
  endgenerate

  assign sum = acc_q + prod;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_mult_param.sv
`default_nettype none
// ============================================================================
// matrix_mult_param : serially loaded single-MAC matrix multiplier, streamed result
// Revision          : 1.0
// ============================================================================
module matrix_mult_param
  import matrix_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 7,
  parameter bit SIGNED  = 1'b0,
  localparam int DIM_W  = calc_dim_w(MAX_DIM),
  localparam int ACC_W  = calc_acc_w(DATA_W, MAX_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM_W-1:0]  M1Xin,
  input  logic [DIM_W-1:0]  M1Yin,
  input  logic [DIM_W-1:0]  M2Xin,
  input  logic [DIM_W-1:0]  M2Yin,
  input  logic              program_dim,
  input  logic              program_val,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  input  logic              result_read_ready,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [ACC_W-1:0]  result_data,
  output logic              result_valid,
  output logic              result_last
);

  localparam int IDX_W = calc_idx_w(MAX_DIM);
  localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_e state_q, state_d;

  logic [DIM_W-1:0] m1x_q, m1x_d;
  logic [DIM_W-1:0] m1y_q, m1y_d;
  logic [DIM_W-1:0] m2x_q, m2x_d;
  logic [DIM_W-1:0] m2y_q, m2y_d;

  logic             ld_m2_q, ld_m2_d;
  logic [IDX_W-1:0] ld_r_q, ld_r_d;
  logic [IDX_W-1:0] ld_c_q, ld_c_d;

  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] k_q, k_d;

  logic             err_q, err_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic [DATA_W-1:0] m1_mem_q [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] m2_mem_q [MAX_DIM][MAX_DIM];

  logic             m1_we;
  logic             m2_we;
  logic             mac_clr;
  logic             mac_en;
  logic [ACC_W-1:0] mac_sum;

  logic [DIM_W-1:0] ld_rows;
  logic [DIM_W-1:0] ld_cols;
  logic             ld_c_last;
  logic             ld_r_last;
  logic             k_last;
  logic             i_last;
  logic             j_last;
  logic             dims_bad;
  logic             dim_window;

  assign ld_rows   = ld_m2_q ? m2y_q : m1y_q;
  assign ld_cols   = ld_m2_q ? m2x_q : m1x_q;
  assign ld_c_last = (DIM_W'(ld_c_q) == (ld_cols - DIM_ONE));
  assign ld_r_last = (DIM_W'(ld_r_q) == (ld_rows - DIM_ONE));
  assign k_last    = (DIM_W'(k_q) == (m1x_q - DIM_ONE));
  assign i_last    = (DIM_W'(i_q) == (m1y_q - DIM_ONE));
  assign j_last    = (DIM_W'(j_q) == (m2x_q - DIM_ONE));

  assign dims_bad = (M1Xin == '0) || (M1Yin == '0) || (M2Xin == '0) || (M2Yin == '0) ||
                    (M1Xin > MAX_DIM_V) || (M1Yin > MAX_DIM_V) ||
                    (M2Xin > MAX_DIM_V) || (M2Yin > MAX_DIM_V) ||
                    (M1Xin != M2Yin);

  assign dim_window = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_LOADED);

  mat_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (m1_mem_q[i_q][k_q]),
    .b   (m2_mem_q[k_q][j_q]),
    .sum (mac_sum)
  );

  always_comb begin
    state_d  = state_q;
    m1x_d    = m1x_q;
    m1y_d    = m1y_q;
    m2x_d    = m2x_q;
    m2y_d    = m2y_q;
    ld_m2_d  = ld_m2_q;
    ld_r_d   = ld_r_q;
    ld_c_d   = ld_c_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    err_d    = err_q;
    result_d = result_q;
    m1_we    = 1'b0;
    m2_we    = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
      end

      ST_LOAD: begin
        if (program_val && !program_dim) begin
          m1_we = !ld_m2_q;
          m2_we = ld_m2_q;
          if (!ld_c_last) begin
            ld_c_d = ld_c_q + IDX_ONE;
          end else begin
            ld_c_d = '0;
            if (!ld_r_last) begin
              ld_r_d = ld_r_q + IDX_ONE;
            end else begin
              ld_r_d = '0;
              if (!ld_m2_q) begin
                ld_m2_d = 1'b1;
              end else begin
                state_d = ST_LOADED;
              end
            end
          end
        end
      end

      ST_LOADED: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        mac_en = 1'b1;
        if (k_last) begin
          result_d = mac_sum;
          state_d  = ST_OUT;
        end else begin
          k_d = k_q + IDX_ONE;
        end
      end

      ST_OUT: begin
        if (result_read_ready) begin
          if (i_last && j_last) begin
            state_d = ST_LOADED;
          end else begin
            if (j_last) begin
              j_d = '0;
              i_d = i_q + IDX_ONE;
            end else begin
              j_d = j_q + IDX_ONE;
            end
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = ST_CALC;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reprogramming wins over any load-data or start in the same cycle
    if (program_dim && dim_window) begin
      m1x_d   = M1Xin;
      m1y_d   = M1Yin;
      m2x_d   = M2Xin;
      m2y_d   = M2Yin;
      ld_m2_d = 1'b0;
      ld_r_d  = '0;
      ld_c_d  = '0;
      err_d   = dims_bad;
      state_d = dims_bad ? ST_IDLE : ST_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m1x_q    <= '0;
      m1y_q    <= '0;
      m2x_q    <= '0;
      m2y_q    <= '0;
      ld_m2_q  <= 1'b0;
      ld_r_q   <= '0;
      ld_c_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      m1x_q    <= m1x_d;
      m1y_q    <= m1y_d;
      m2x_q    <= m2x_d;
      m2y_q    <= m2y_d;
      ld_m2_q  <= ld_m2_d;
      ld_r_q   <= ld_r_d;
      ld_c_q   <= ld_c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Operand storage survives reset; only a fresh load overwrites it
  always_ff @(posedge clk) begin
    if (m1_we) begin
      m1_mem_q[ld_r_q][ld_c_q] <= data_in;
    end
    if (m2_we) begin
      m2_mem_q[ld_r_q][ld_c_q] <= data_in;
    end
  end

  assign ready        = (state_q == ST_LOADED);
  assign busy         = (state_q == ST_CALC) || (state_q == ST_OUT);
  assign err          = err_q;
  assign result_data  = result_q;
  assign result_valid = (state_q == ST_OUT);
  assign result_last  = (state_q == ST_OUT) && i_last && j_last;

endmodule
`default_nettype wire

// File: tb/tb_matrix_mult_param.sv
`default_nettype none
// ============================================================================
// tb_matrix_mult_param : unsigned and signed instances driven in lockstep,
//                        checked against a plain-arithmetic matrix model
// Revision             : 1.0
// ============================================================================
module tb_matrix_mult_param;

  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 7;
  localparam int DIM_W   = 3;
  localparam int ACC_W   = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [DIM_W-1:0]  M1Xin, M1Yin, M2Xin, M2Yin;
  logic              program_dim, program_val, start, result_read_ready;
  logic [DATA_W-1:0] data_in;

  logic             u_ready, u_busy, u_err, u_valid, u_last;
  logic [ACC_W-1:0] u_data;
  logic             s_ready, s_busy, s_err, s_valid, s_last;
  logic [ACC_W-1:0] s_data;

  matrix_mult_param #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .M1Xin(M1Xin), .M1Yin(M1Yin), .M2Xin(M2Xin), .M2Yin(M2Yin),
    .program_dim(program_dim), .program_val(program_val), .data_in(data_in),
    .start(start), .result_read_ready(result_read_ready),
    .ready(u_ready), .busy(u_busy), .err(u_err), .result_data(u_data),
    .result_valid(u_valid), .result_last(u_last));

  matrix_mult_param #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .M1Xin(M1Xin), .M1Yin(M1Yin), .M2Xin(M2Xin), .M2Yin(M2Yin),
    .program_dim(program_dim), .program_val(program_val), .data_in(data_in),
    .start(start), .result_read_ready(result_read_ready),
    .ready(s_ready), .busy(s_busy), .err(s_err), .result_data(s_data),
    .result_valid(s_valid), .result_last(s_last));

  int n_checks = 0;
  int n_pass   = 0;

  int a_m [MAX_DIM][MAX_DIM];
  int b_m [MAX_DIM][MAX_DIM];
  logic [ACC_W-1:0] exp_u [$];
  logic [ACC_W-1:0] exp_s [$];
  int cur_m1x, cur_m1y, cur_m2x, cur_m2y;

  typedef struct {
    logic [DIM_W-1:0] x1, y1, x2, y2;
    bit               exp_err;
  } dim_vec_t;

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sext8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic program_dims(input int x1, input int y1, input int x2, input int y2);
    M1Xin = DIM_W'(x1); M1Yin = DIM_W'(y1); M2Xin = DIM_W'(x2); M2Yin = DIM_W'(y2);
    program_dim = 1'b1;
    tick();
    program_dim = 1'b0;
    cur_m1x = x1; cur_m1y = y1; cur_m2x = x2; cur_m2y = y2;
  endtask

  task automatic load_ops();
    for (int r = 0; r < cur_m1y; r++)
      for (int c = 0; c < cur_m1x; c++) begin
        data_in = DATA_W'(a_m[r][c]); program_val = 1'b1; tick();
      end
    for (int r = 0; r < cur_m2y; r++)
      for (int c = 0; c < cur_m2x; c++) begin
        data_in = DATA_W'(b_m[r][c]); program_val = 1'b1; tick();
      end
    program_val = 1'b0;
  endtask

  task automatic build_expected();
    int su, ss;
    exp_u.delete();
    exp_s.delete();
    for (int i = 0; i < cur_m1y; i++)
      for (int j = 0; j < cur_m2x; j++) begin
        su = 0; ss = 0;
        for (int k = 0; k < cur_m1x; k++) begin
          su += a_m[i][k] * b_m[k][j];
          ss += sext8(a_m[i][k]) * sext8(b_m[k][j]);
        end
        exp_u.push_back(ACC_W'(su));
        exp_s.push_back(ACC_W'(ss));
      end
  endtask

  task automatic fill_const(input int av, input int bv);
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        a_m[r][c] = av; b_m[r][c] = bv;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        a_m[r][c] = int'($urandom_range(0, 255));
        b_m[r][c] = int'($urandom_range(0, 255));
      end
  endtask

  // rr_mode: 0 always ready, 1 toggling, 2 hold low 10 cycles on first element, 3 random
  task automatic run_stream(input string name, input int rr_mode, input bit extra_start,
                            output int first_lat);
    int n_el, got, cyc, held;
    bit rr;
    n_el = exp_u.size();
    got = 0; cyc = 0; held = 0; first_lat = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (got < n_el && cyc < 5000) begin
      start = (extra_start && cyc == 0);
      if (u_valid && first_lat < 0) first_lat = cyc + 1;
      case (rr_mode)
        0: rr = 1'b1;
        1: rr = cyc[0];
        2: begin
          rr = 1'b1;
          if (u_valid && got == 0 && held < 10) begin
            rr = 1'b0;
            held++;
            check({name, "_held_data"}, u_data, exp_u[0]);
          end
        end
        default: rr = 1'($urandom_range(0, 1));
      endcase
      result_read_ready = rr;
      if (u_valid && rr) begin
        check({name, "_udata"}, u_data, exp_u[got]);
        check({name, "_sdata"}, s_data, exp_s[got]);
        check({name, "_ulast"}, ACC_W'(u_last), ACC_W'(got == n_el - 1));
        check({name, "_slast"}, ACC_W'(s_last), ACC_W'(got == n_el - 1));
        got++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    result_read_ready = 1'b0;
    check({name, "_count"}, ACC_W'(got), ACC_W'(n_el));
    check({name, "_ready_after"}, ACC_W'(u_ready), 1);
    check({name, "_busy_after"}, ACC_W'(s_busy), 0);
  endtask

  dim_vec_t dv [7];
  int lat, got, cyc;

  initial begin
    rst = 1'b1; program_dim = 1'b0; program_val = 1'b0; start = 1'b0;
    result_read_ready = 1'b0; data_in = '0;
    M1Xin = '0; M1Yin = '0; M2Xin = '0; M2Yin = '0;
    tick(); tick();
    check("rst_ready", ACC_W'(u_ready), 0);
    check("rst_busy",  ACC_W'(u_busy), 0);
    check("rst_err",   ACC_W'(s_err), 0);
    check("rst_data",  u_data, 0);
    check("rst_valid", ACC_W'(s_valid), 0);
    check("rst_last",  ACC_W'(u_last), 0);
    rst = 1'b0;
    tick();

    dv[0] = '{3'd3, 3'd5, 3'd5, 3'd5, 1'b1};
    dv[1] = '{3'd0, 3'd2, 3'd2, 3'd0, 1'b1};
    dv[2] = '{3'd2, 3'd3, 3'd4, 3'd2, 1'b0};
    dv[3] = '{3'd4, 3'd1, 3'd1, 3'd5, 1'b1};
    dv[4] = '{3'd1, 3'd1, 3'd1, 3'd1, 1'b0};
    dv[5] = '{3'd7, 3'd7, 3'd0, 3'd7, 1'b1};
    dv[6] = '{3'd7, 3'd7, 3'd7, 3'd7, 1'b0};
    for (int n = 0; n < 7; n++) begin
      program_dims(dv[n].x1, dv[n].y1, dv[n].x2, dv[n].y2);
      check($sformatf("dim%0d_err_u", n), ACC_W'(u_err), ACC_W'(dv[n].exp_err));
      check($sformatf("dim%0d_err_s", n), ACC_W'(s_err), ACC_W'(dv[n].exp_err));
      check($sformatf("dim%0d_ready", n), ACC_W'(u_ready), 0);
    end

    // Shape error, then the compatible shape with all-ones operands
    program_dims(3, 5, 5, 5);
    check("shape_err", ACC_W'(u_err), 1);
    start = 1'b1; tick(); start = 1'b0;
    check("shape_start_ignored", ACC_W'(u_busy), 0);
    program_dims(3, 5, 5, 3);
    check("shape_err_clr", ACC_W'(u_err), 0);
    fill_const(1, 1);
    load_ops();
    check("shape_ready", ACC_W'(u_ready), 1);
    build_expected();
    run_stream("ones", 0, 1'b0, lat);

    // Identity: latency K+1 edges from start sample
    program_dims(2, 2, 2, 2);
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 1; b_m[0][1] = 0; b_m[1][0] = 0; b_m[1][1] = 1;
    load_ops();
    build_expected();
    run_stream("ident", 0, 1'b0, lat);
    check("ident_latency", ACC_W'(lat), 3);

    // Extreme operands at maximum size
    program_dims(7, 7, 7, 7);
    fill_const(128, 128);
    load_ops();
    build_expected();
    run_stream("m128", 1, 1'b0, lat);
    check("m128_value_u", exp_u[0], ACC_W'(114688));
    program_dims(7, 7, 7, 7);
    fill_const(255, 255);
    load_ops();
    build_expected();
    run_stream("f255", 0, 1'b0, lat);
    check("f255_latency", ACC_W'(lat), 8);

    // Rerun without reload, with backpressure and a stray start during CALC
    run_stream("rerun_bp", 2, 1'b1, lat);
    run_stream("rerun_tog", 1, 1'b0, lat);

    // Random shapes and data against the model
    for (int n = 0; n < 4; n++) begin
      int kk;
      kk = int'($urandom_range(1, 7));
      program_dims(kk, int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), kk);
      fill_random();
      load_ops();
      build_expected();
      run_stream($sformatf("rnd%0d", n), 3, 1'b0, lat);
    end

    // Reset while the third element is waiting
    program_dims(3, 3, 3, 3);
    fill_random();
    load_ops();
    start = 1'b1; tick(); start = 1'b0;
    got = 0; cyc = 0;
    result_read_ready = 1'b1;
    while (cyc < 2000 && !(got == 2 && u_valid)) begin
      if (u_valid) got++;
      tick();
      cyc++;
    end
    result_read_ready = 1'b0;
    check("midrst_reached", ACC_W'(got), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_valid", ACC_W'(u_valid), 0);
    check("midrst_data_u", u_data, 0);
    check("midrst_data_s", s_data, 0);
    check("midrst_busy", ACC_W'(s_busy), 0);
    check("midrst_ready", ACC_W'(u_ready), 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("midrst_start_ignored", ACC_W'(u_busy), 0);
    check("midrst_no_valid", ACC_W'(s_valid), 0);
    program_dims(3, 3, 3, 3);
    load_ops();
    build_expected();
    run_stream("after_rst", 0, 1'b0, lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_mult_param.md
# matrix_mult_param

Parametrised, single-MAC matrix multiplier, the successor to the fixed 8-bit `matrix` block. Dimensions and operands are programmed serially; the product is streamed out element by element under a valid/ready handshake. Data width, maximum dimension and signedness are generics. Dimension errors are flagged, and loaded operands can be re-multiplied without reloading.

## Interface
- `DATA_W`, default 8: operand width.
- `MAX_DIM`, default 7: maximum rows/columns of any matrix.
- `SIGNED`, default 0: 1 selects two's-complement operands and result.
- `DIM_W`, derived, `$clog2(MAX_DIM+1)`: dimension port width.
- `ACC_W`, derived, `2*DATA_W + $clog2(MAX_DIM)`: result width.
- `clk  in  1`: single clock. All logic is on the rising edge.
- `rst  in  1`: synchronous reset, active-high.
- `M1Xin`, `M1Yin`, `M2Xin`, `M2Yin`  in  DIM_W: column/row counts. X is columns, Y is rows.
- `program_dim  in  1`: latches the dimensions.
- `program_val  in  1`: qualifies `data_in`.
- `data_in  in  DATA_W`: operand stream.
- `start  in  1`: begins the multiply.
- `result_read_ready  in  1`: consumer accepts `result_data`.
- `ready  out  1`: operands are loaded and `start` is accepted.
- `busy  out  1`: high in CALC and OUT.
- `err  out  1`: sticky dimension error.
- `result_data  out  ACC_W`: product element.
- `result_valid  out  1`: `result_data` is valid.
- `result_last  out  1`: marks the final element, qualified by `result_valid`.

## Operation
- States are IDLE, LOAD, LOADED, CALC, OUT.
- Reset:
  - State goes to IDLE.
  - Every output goes to 0.
  - Operand memories are not cleared.
- `program_dim` is honoured in IDLE, LOAD and LOADED, and ignored in CALC and OUT.
  - On `program_dim`, the four dimensions are latched, the load pointer is cleared and `err` is cleared.
  - `err` is set and the state goes to IDLE if any dimension is 0, any dimension is greater than `MAX_DIM`, or `M1Xin != M2Yin`.
  - Otherwise the state goes to LOAD.
- LOAD:
  - Each cycle with `program_val` writes `data_in` to the next element.
  - Order is M1 row-major (M1Y·M1X elements), then M2 row-major (M2Y·M2X elements).
  - The write of the last element moves the state to LOADED.
  - `program_val` is ignored in every other state.
- LOADED:
  - `ready` is 1.
  - `start` moves the state to CALC, with row i=0, column j=0, k=0 and the accumulator cleared.
  - `start` is ignored in every other state.
- CALC:
  - One MAC per cycle: acc += M1[i][k]·M2[k][j].
  - At k = K−1 (K = M1X), `result_data` is set to the final sum and the state goes to OUT.
- OUT:
  - `result_valid` is 1 and `result_data` holds its value.
  - On `result_valid && result_read_ready` at a rising edge, the element is consumed.
  - If it was not the last element, j advances (wrapping to 0 with i+1), the accumulator clears, and the state goes to CALC.
  - If it was the last element, the state returns to LOADED.
- Elements are emitted in row-major order over the result, which is M1Y × M2X.
- Arithmetic:
  - Products and sums are computed at full ACC_W, signed or unsigned per `SIGNED`.
  - Overflow cannot occur within the parameter bounds.
- Simultaneous `program_dim` and `program_val`: `program_dim` wins and the data is dropped.
- Reset mid-operation aborts immediately and the state goes to IDLE. A new `program_dim` and a full reload are required.

## Timing
- `start` sampled at edge T: CALC runs T+1..T+K, and `result_valid` rises after edge T+K.
- Each subsequent element: `result_valid` falls on the edge after the handshake and rises again K cycles later.
- Throughput is one element per K+1 cycles with `result_read_ready` held high.
- `ready` falls on the edge that accepts `start`, and rises on the edge of the final handshake.
- `result_last` is 1 only while the final element is valid.
- `err` changes only on `program_dim` or `rst`.

## Structure
- Package `matrix_pkg` contains the state enum and functions computing `DIM_W` and `ACC_W` from the parameters.
- Sub-module `mat_mac` is a registered multiply-accumulate with clear, enable and `SIGNED` parameter. All other logic is the top-level FSM, address generation and two register arrays of MAX_DIM² entries.

## Test plan
- **Shape error:** dims 3,5,5,5 → `err`=1 and state stays IDLE. Then dims M1X=3, M1Y=5, M2X=5, M2Y=3, `data_in`=1 for 30 cycles, `start` → 25 elements each equal to 3, with `result_last` on the 25th.
- **Identity:** 2×2 [[1,2],[3,4]] × identity → outputs 1, 2, 3, 4. First valid is 3 cycles after `start` (K=2).
- **Signed:** `SIGNED`=1, 7×7 of −128 times 7×7 of −128 → every element equals 114688. The same vectors with `SIGNED`=0 give 7·128·128 = 114688, and 255 inputs give 455175.
- **Backpressure:** hold `result_read_ready` low for 10 cycles → `result_data` is stable and the element is not skipped. Toggle `result_read_ready` every cycle → the full sequence is correct.
- **Rerun:** after completion, pulse `start` again with no reload → identical output stream. `start` pulsed during CALC is ignored.
- **Reset mid-operation:** assert `rst` during the third OUT element → all outputs are 0 next cycle, `start` is ignored until dims and operands are reprogrammed.
